// File: rtl/adder_share_sched.sv
// Round-robin scheduler time-sharing one registered multi-input adder among
// NUM_REQ requesters. Sums come back tagged with the requester index through a
// 2-entry result FIFO.
module adder_share_sched #(
  parameter int NUM_REQ       = 4,
  parameter int NUM_INPUT     = 2,
  parameter int DATA_WIDTH_IN = 16,
  localparam int SUM_W        = DATA_WIDTH_IN + $clog2(NUM_INPUT),
  localparam int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic signed [DATA_WIDTH_IN-1:0] req_data [NUM_REQ][NUM_INPUT],
  output logic signed [DATA_WIDTH_IN-1:0] add_din [NUM_INPUT],
  output logic                            add_ena,
  input  logic signed [SUM_W-1:0]         add_dout,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic signed [SUM_W-1:0]         res_data,
  output logic [ID_W-1:0]                 res_id
);

  if (DATA_WIDTH_IN <= 0) begin : g_bad_width
    $error("adder_share_sched: DATA_WIDTH_IN must be > 0");
  end
  if (NUM_REQ < 2) begin : g_bad_req
    $error("adder_share_sched: NUM_REQ must be >= 2");
  end

  logic [ID_W-1:0]         rr_q;
  logic [ID_W-1:0]         tag_q;
  logic                    inflight_q;
  logic [1:0]              count_q, count_d;
  logic signed [SUM_W-1:0] data_q [2];
  logic signed [SUM_W-1:0] data_d [2];
  logic [ID_W-1:0]         id_q [2];
  logic [ID_W-1:0]         id_d [2];

  logic            pop;
  logic [2:0]      occupancy;
  logic            issue_ok;
  logic            found;
  logic [ID_W-1:0] win;
  logic [ID_W-1:0] idx;
  logic [ID_W-1:0] sel;
  logic            grant;
  logic [1:0]      fill;

  assign res_valid = (count_q != 2'd0);
  assign res_data  = data_q[0];
  assign res_id    = id_q[0];
  assign pop       = res_valid && res_ready;

  // Slots committed after this cycle's pop; an issue must leave room for its sum.
  assign occupancy = 3'(count_q) + 3'(inflight_q) - 3'(pop);
  assign issue_ok  = (occupancy < 3'd2);

  // Round-robin search starting just after the last winner.
  always_comb begin
    found = 1'b0;
    win   = rr_q;
    idx   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = ID_W'((int'(rr_q) + off) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Reset gates the grant so nothing handshakes while the block is held in reset.
  assign grant = rst_n && found && issue_ok;

  // Grant, adder enable and adder operand mux.
  always_comb begin
    req_ready = '0;
    add_ena   = grant;
    sel       = grant ? win : rr_q;
    if (grant) begin
      req_ready[win] = 1'b1;
    end
    for (int j = 0; j < NUM_INPUT; j++) begin
      add_din[j] = req_data[sel][j];
    end
  end

  // Arbiter pointer, in-flight flag and requester tag of the sum in the adder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q       <= ID_W'(NUM_REQ - 1);
      tag_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= grant;
      if (grant) begin
        rr_q  <= win;
        tag_q <= win;
      end
    end
  end

  // FIFO next state: pop shifts entry 1 to the head, push lands after survivors.
  always_comb begin
    data_d  = data_q;
    id_d    = id_q;
    fill    = count_q - 2'(pop);
    if (pop) begin
      data_d[0] = data_q[1];
      id_d[0]   = id_q[1];
    end
    if (inflight_q) begin
      data_d[fill[0]] = add_dout;
      id_d[fill[0]]   = tag_q;
    end
    count_d = fill + 2'(inflight_q);
  end

  // Result FIFO storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        id_q[i]   <= '0;
      end
    end else begin
      count_q <= count_d;
      data_q  <= data_d;
      id_q    <= id_d;
    end
  end

endmodule

// File: tb/tb_adder_share_sched.sv
// Self-checking bench for adder_share_sched: table of single-vector sums,
// hand-written arbitration/backpressure/reset sequences and random traffic
// checked against a transaction-level reference model.
module tb_adder_share_sched;

  localparam int NR = 4;
  localparam int NI = 2;
  localparam int W  = 16;
  localparam int SW = 17;
  localparam int IW = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NR-1:0]        req_valid;
  logic [NR-1:0]        req_ready;
  logic signed [W-1:0]  req_data [NR][NI];
  logic signed [W-1:0]  add_din [NI];
  logic                 add_ena;
  logic signed [SW-1:0] add_dout;
  logic                 res_valid;
  logic                 res_ready;
  logic signed [SW-1:0] res_data;
  logic [IW-1:0]        res_id;

  always #5 clk = ~clk;

  adder_share_sched #(
    .NUM_REQ      (NR),
    .NUM_INPUT    (NI),
    .DATA_WIDTH_IN(W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_data (req_data),
    .add_din  (add_din),
    .add_ena  (add_ena),
    .add_dout (add_dout),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .res_id   (res_id)
  );

  // Shared registered adder: holds while add_ena is low.
  function automatic longint din_sum();
    longint s = 0;
    for (int j = 0; j < NI; j++) s += longint'(add_din[j]);
    return s;
  endfunction

  always @(posedge clk) begin
    if (add_ena) add_dout <= SW'(din_sum());
  end

  // ---------------- reference model ----------------
  typedef struct {
    longint sum;
    int     id;
    int     cyc;
  } res_t;

  res_t mq[$];
  int   m_rr;
  int   cyc;
  int   n_chk;
  int   n_fail;
  int   last_g;
  int   last_pop_id;

  task automatic check(input string name, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic longint req_sum(input int r);
    longint s = 0;
    for (int j = 0; j < NI; j++) s += longint'(req_data[r][j]);
    return s;
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_rr = NR - 1;
  endfunction

  // Compare this cycle's outputs with the model, then advance the model.
  task automatic model_check();
    bit head_rdy;
    bit pop;
    int occ;
    int g;
    head_rdy = (mq.size() > 0) && (mq[0].cyc + 2 <= cyc);
    pop      = head_rdy && res_ready;
    occ      = mq.size() - int'(pop);
    g        = -1;
    if (occ < 2) begin
      for (int off = 1; off <= NR; off++) begin
        int r;
        r = (m_rr + off) % NR;
        if (g < 0 && req_valid[r]) g = r;
      end
    end
    check("req_ready", req_ready, (g >= 0) ? (1 << g) : 0);
    check("add_ena", add_ena, g >= 0);
    if (g >= 0) begin
      for (int j = 0; j < NI; j++) check("add_din", add_din[j], req_data[g][j]);
    end
    check("res_valid", res_valid, head_rdy);
    if (head_rdy) begin
      check("res_data", res_data, mq[0].sum);
      check("res_id", res_id, mq[0].id);
    end
    last_pop_id = -1;
    if (pop) begin
      last_pop_id = mq[0].id;
      void'(mq.pop_front());
    end
    last_g = g;
    if (g >= 0) begin
      res_t e;
      e.sum = req_sum(g);
      e.id  = g;
      e.cyc = cyc;
      mq.push_back(e);
      m_rr = g;
    end
    cyc++;
  endtask

  task automatic sample();
    @(negedge clk);
    model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_data();
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < NI; j++) req_data[i][j] = W'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_add_ena"}, add_ena, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_data"}, res_data, 0);
    check({tag, "_res_id"}, res_id, 0);
  endtask

  task automatic reset_dut();
    req_valid = '1;
    res_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    check_reset_outputs("rst");
    model_reset();
    advance();
    advance();
    rst_n = 1'b1;
  endtask

  task automatic drain(input int n);
    req_valid = '0;
    res_ready = 1'b1;
    repeat (n) begin
      sample();
      advance();
    end
  endtask

  typedef struct {
    int id;
    int a;
    int b;
    int exp_sum;
  } vec_t;

  vec_t tbl[6];
  int   issues;
  int   pops;
  bit   seen1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    add_dout = '0;
    req_valid = '1;
    res_ready = 1'b0;
    randomize_data();
    model_reset();

    tbl[0] = '{0, 3, -5, -2};
    tbl[1] = '{1, 32767, 32767, 65534};
    tbl[2] = '{2, -32768, -32768, -65536};
    tbl[3] = '{3, 100, -100, 0};
    tbl[4] = '{0, -1, -1, -2};
    tbl[5] = '{2, 32767, -32768, -1};

    // Held in reset with every requester asking: all outputs stay 0.
    #12;
    check_reset_outputs("por");
    advance();
    rst_n = 1'b1;

    // Single-vector sums with fixed latency: grant T, nothing T+1, result T+2.
    for (int k = 0; k < 6; k++) begin
      drain(3);
      req_data[tbl[k].id][0] = W'(tbl[k].a);
      req_data[tbl[k].id][1] = W'(tbl[k].b);
      req_valid = NR'(1 << tbl[k].id);
      sample();
      check("tbl_grant", req_ready, 1 << tbl[k].id);
      advance();
      req_valid = '0;
      sample();
      check("tbl_t1_valid", res_valid, 0);
      advance();
      sample();
      check("tbl_t2_valid", res_valid, 1);
      check("tbl_sum", res_data, tbl[k].exp_sum);
      check("tbl_id", res_id, tbl[k].id);
      advance();
    end

    // Round robin from reset, full throughput, one push and one pop per cycle.
    reset_dut();
    req_valid = '1;
    res_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      randomize_data();
      sample();
      check("rr_grant", req_ready, 1 << (k % NR));
      if (k >= 2) check("rr_res_id", res_id, (k - 2) % NR);
      advance();
    end

    // Backpressure: two issues fill the FIFO, then the arbiter stalls.
    drain(4);
    req_valid = '1;
    res_ready = 1'b0;
    issues = 0;
    for (int k = 0; k < 6; k++) begin
      sample();
      issues += int'(add_ena);
      if (k >= 2) begin
        check("bp_stall_ready", req_ready, 0);
        check("bp_stall_ena", add_ena, 0);
      end
      advance();
    end
    check("bp_issue_count", issues, 2);
    res_ready = 1'b1;
    sample();
    check("bp_pop_issue", add_ena, 1);
    advance();
    res_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sample();
      check("bp_restall_ena", add_ena, 0);
      advance();
    end
    req_valid = '0;
    res_ready = 1'b1;
    pops = 0;
    for (int k = 0; k < 5; k++) begin
      sample();
      pops += int'(res_valid);
      advance();
    end
    check("bp_drain_pops", pops, 2);

    // Wrap-around after a grant to the last requester.
    req_valid = 4'b1000;
    sample();
    check("wrap_g3", req_ready, 4'b1000);
    advance();
    req_valid = 4'b0100;
    sample();
    check("wrap_g2", req_ready, 4'b0100);
    advance();
    req_valid = 4'b1000;
    sample();
    check("wrap_g3b", req_ready, 4'b1000);
    advance();
    req_valid = 4'b0101;
    sample();
    check("wrap_g0", req_ready, 4'b0001);
    advance();
    drain(4);

    // Requester 1 loses arbitration, then withdraws; it must never be served.
    seen1 = 1'b0;
    req_valid = 4'b1000;
    sample();
    advance();
    req_valid = 4'b0011;
    sample();
    check("drop_g0a", req_ready, 4'b0001);
    if (last_pop_id == 1) seen1 = 1'b1;
    advance();
    req_valid = 4'b0001;
    sample();
    check("drop_g0b", req_ready, 4'b0001);
    if (last_pop_id == 1) seen1 = 1'b1;
    advance();
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      sample();
      if (last_pop_id == 1) seen1 = 1'b1;
      advance();
    end
    check("drop_never_id1", seen1, 0);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      req_valid = NR'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      randomize_data();
      sample();
      advance();
    end

    // Reset while a sum is in flight: it must be discarded.
    drain(4);
    req_valid = 4'b0001;
    res_ready = 1'b0;
    sample();
    check("mid_issue", add_ena, 1);
    advance();
    req_valid = 4'b0010;
    sample();
    advance();
    req_valid = '1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid");
    model_reset();
    advance();
    advance();
    rst_n = 1'b1;
    req_valid = '0;
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sample();
      check("mid_no_stale", res_valid, 0);
      advance();
    end

    for (int k = 0; k < 200; k++) begin
      req_valid = NR'($urandom);
      res_ready = ($urandom_range(0, 1) != 0);
      randomize_data();
      sample();
      advance();
    end
    drain(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_share_sched.md
# adder_share_sched

Round-robin scheduler that time-shares one registered multi-input adder among NUM_REQ requesters. Each requester offers a vector of NUM_INPUT signed samples over a valid/ready handshake. The scheduler drives the shared adder's data and enable inputs and captures each sum one cycle later. It returns each sum, tagged with the requester index, through a 2-entry result FIFO with its own valid/ready handshake. It sits between per-channel DSP front ends and the shared summation datapath.

## Interface
- NUM_REQ, default 4: number of requesters; must be ≥ 2.
- NUM_INPUT, default 2: samples per vector; equals the adder's input count.
- DATA_WIDTH_IN, default 16: signed sample width; must be > 0 (elaboration `$error` otherwise).
- Derived SUM_W = DATA_WIDTH_IN + $clog2(NUM_INPUT); ID_W = $clog2(NUM_REQ).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester vector valid.
- req_ready  out  NUM_REQ  one-hot grant; handshake completes when req_valid[i] and req_ready[i].
- req_data  in  signed [DATA_WIDTH_IN-1:0] [NUM_REQ][NUM_INPUT]  sample vectors.
- add_din  out  signed [DATA_WIDTH_IN-1:0] [NUM_INPUT]  to shared adder data input.
- add_ena  out  1  to shared adder enable.
- add_dout  in  signed [SUM_W-1:0]  from shared adder; valid the cycle after add_ena.
- res_valid  out  1  result FIFO head valid.
- res_ready  in  1  consumer accepts head.
- res_data  out  signed [SUM_W-1:0]  sum.
- res_id  out  ID_W  index of the requester whose vector produced res_data.

## Operation
- Arbitration is combinational each cycle:
  - Candidates are the requesters with req_valid high.
  - Search starts at rr_ptr+1 mod NUM_REQ; the first candidate found wins.
  - req_ready is high only for the winner, and only when issue_ok.
- issue_ok = (fifo_count + inflight − pop) < 2.
  - pop = res_valid && res_ready.
  - inflight = an issue happened in the previous cycle.
  - Result slots are therefore never overcommitted. No sum is ever lost or overwritten.
- On a grant to requester g:
  - add_din = req_data[g] and add_ena = 1 in the same cycle, combinationally.
  - rr_ptr ← g; inflight ← 1; the tag register ← g.
- With no grant: add_ena = 0 and add_din = req_data[rr_ptr]. The adder holds while add_ena is low, so add_din is don't-care then.
- Capture: in the cycle after an issue, add_dout is pushed with the tag into the FIFO tail.
- FIFO:
  - 2 entries; res_valid = (fifo_count ≠ 0).
  - res_data and res_id show the head entry.
  - Push and pop in the same cycle are both honoured, count unchanged.
  - Push into an empty FIFO appears at the head the next cycle.
- Arithmetic: the scheduler does not modify sums. res_data is add_dout bit-for-bit, with SUM_W wide and no saturation.
- A requester that drops req_valid before being granted is simply skipped. No state is kept for it.

## Timing
- Reset (rst_n low, asynchronous) clears the FIFO, inflight and the tag register, and sets rr_ptr = NUM_REQ−1 so requester 0 has first priority.
  - Registered outputs are 0 during reset: res_valid, res_data, res_id.
  - add_ena and req_ready are also 0 during reset.
  - An in-flight sum is discarded.
- Release of reset is synchronised externally. The first grant can occur in the first cycle after deassertion.
- Latency:
  - Cycle T: grant, add_ena = 1.
  - Edge T+1: the adder registers the sum.
  - Edge T+2: the sum is pushed into the FIFO.
  - Cycle T+2: res_valid = 1, if the FIFO was empty.
- Throughput is 1 vector per cycle while res_ready is held high.
- FIFO full (count 2), no pop, no inflight: all req_ready = 0 and add_ena = 0.
- Count 1 with inflight and no pop: no issue that cycle.
- Count 2 with pop: one issue is allowed.
- Wrap-around: rr_ptr = NUM_REQ−1 searches from requester 0.

## Test plan
- Reset, then req_valid=4'b0001 with samples {3, −5} → grant at T, res_valid at T+2, res_data = −2, res_id = 0. All outputs 0 during reset.
- All four requesters valid, res_ready=1 → grants in order 0,1,2,3,0,… one per cycle. res_id follows the same sequence two cycles later.
- res_ready=0 with all valid → exactly 2 issues, then req_ready=0 and add_ena=0 indefinitely. res_ready=1 for one cycle → exactly one more issue. No result lost or duplicated.
- Samples {32767, 32767}, DATA_WIDTH_IN=16, NUM_INPUT=2 → res_data = 65534 (17-bit signed). Samples {−32768, −32768} → res_data = −65536.
- Simultaneous push and pop at count 1 → count stays 1 and head/tail order is preserved. rst_n pulsed low while inflight=1 → res_valid=0 and no stale result appears after release.
- Requester 2 alone valid after last grant to 3 → wrap search grants 2. Requester 1 deasserts before grant → never appears in res_id.
